// File: rtl/sigmoid_inv_8bit.sv
// Inverse sigmoid: bisection search for the smallest Q4.4 x whose forward sigmoid model reaches y.
// Optional residual output f(out_x) - y is enabled with the SIGMOID_INV_RESID_EN macro.
module sigmoid_inv_8bit #(
    parameter int ITERATIONS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_y,
    output logic       out_valid,
    input  logic       out_ready,
`ifdef SIGMOID_INV_RESID_EN
    output logic [7:0] out_resid,
`endif
    output logic [7:0] out_x
);

    localparam int ITER_W = $clog2(ITERATIONS + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // Piecewise-linear forward sigmoid; 10 bits so that 256 (= 1.0) is representable.
    function automatic logic [9:0] fwd(input logic [7:0] x);
        logic [8:0] a;
        logic [9:0] fp;
        a = x[7] ? (9'd256 - {1'b0, x}) : {1'b0, x};
        if (a < 9'd16)
            fp = {a[7:0], 2'b00} + 10'd128;
        else if (a < 9'd38)
            fp = {a, 1'b0} + 10'd160;
        else if (a < 9'd80)
            fp = {2'b00, a[8:1]} + 10'd216;
        else
            fp = 10'd256;
        if (!x[7])
            fwd = (fp > 10'd255) ? 10'd255 : fp;
        else
            fwd = 10'd256 - fp;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [7:0]        lo_q, lo_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        y_q, y_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [7:0]        out_x_q, out_x_d;

    logic [8:0] mid_sum;
    logic [7:0] mid;
    logic [7:0] eval_u;
    logic [9:0] f_eval;
    logic       finalize;
    logic       ge;

    assign mid_sum  = {1'b0, lo_q} + {1'b0, hi_q};
    assign mid      = 8'(mid_sum >> 1);
    assign finalize = (iter_q == ITER_W'(ITERATIONS));

`ifdef SIGMOID_INV_RESID_EN
    logic [7:0] resid_q, resid_d;
    logic [9:0] diff;

    // The finalize cycle reuses the single evaluator on lo to form the residual.
    assign eval_u = finalize ? lo_q : mid;
    assign diff   = f_eval - {2'b00, y_q};
`else
    assign eval_u = mid;
`endif

    // u = x + 128, so flipping the MSB converts the search index back to signed x.
    assign f_eval = fwd(eval_u ^ 8'h80);
    assign ge     = (f_eval >= {2'b00, y_q});

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        y_d     = y_q;
        iter_d  = iter_q;
        out_x_d = out_x_q;
`ifdef SIGMOID_INV_RESID_EN
        resid_d = resid_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    y_d     = in_y;
                    lo_d    = 8'd0;
                    hi_d    = 8'd255;
                    iter_d  = '0;
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (finalize) begin
                    out_x_d = lo_q ^ 8'h80;
`ifdef SIGMOID_INV_RESID_EN
                    if (f_eval < {2'b00, y_q})
                        resid_d = 8'd0;
                    else if (diff > 10'd255)
                        resid_d = 8'd255;
                    else
                        resid_d = diff[7:0];
`endif
                    state_d = S_DONE;
                end else begin
                    if (lo_q < hi_q) begin
                        if (ge)
                            hi_d = mid;
                        else
                            lo_d = mid + 8'd1;
                    end
                    iter_d = iter_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lo_q    <= 8'd0;
            hi_q    <= 8'd255;
            y_q     <= 8'd0;
            iter_q  <= '0;
            out_x_q <= 8'd0;
`ifdef SIGMOID_INV_RESID_EN
            resid_q <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            y_q     <= y_d;
            iter_q  <= iter_d;
            out_x_q <= out_x_d;
`ifdef SIGMOID_INV_RESID_EN
            resid_q <= resid_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_x     = out_x_q;
`ifdef SIGMOID_INV_RESID_EN
    assign out_resid = resid_q;
`endif

endmodule

// File: tb/tb_sigmoid_inv_8bit.sv
// Directed-vector bench for sigmoid_inv_8bit (exact 8-step build plus a 4-step build).
module tb_sigmoid_inv_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_y, out_x;
    logic       in_valid4, in_ready4, out_valid4, out_ready4;
    logic [7:0] in_y4, out_x4;
`ifdef SIGMOID_INV_RESID_EN
    logic [7:0] out_resid, out_resid4;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sigmoid_inv_8bit #(.ITERATIONS(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef SIGMOID_INV_RESID_EN
        .out_resid(out_resid),
`endif
        .out_x(out_x)
    );

    sigmoid_inv_8bit #(.ITERATIONS(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_y(in_y4),
        .out_valid(out_valid4), .out_ready(out_ready4),
`ifdef SIGMOID_INV_RESID_EN
        .out_resid(out_resid4),
`endif
        .out_x(out_x4)
    );

    typedef struct {
        logic [7:0] y;
        logic [7:0] x;
        string      nm;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    function automatic int f_ref(input int x);
        int a, fp;
        a = (x < 0) ? -x : x;
        if (a < 16)      fp = 4 * a + 128;
        else if (a < 38) fp = 2 * a + 160;
        else if (a < 80) fp = a / 2 + 216;
        else             fp = 256;
        if (x >= 0) return (fp > 255) ? 255 : fp;
        return 256 - fp;
    endfunction

    function automatic int ref_x(input int y);
        for (int x = -128; x < 128; x++)
            if (f_ref(x) >= y) return x;
        return 127;
    endfunction

    // One request on the selected DUT; checks acceptance, latency, busy ready, result.
    task automatic run_req(input bit sel, input logic [7:0] y, input logic [7:0] exp_x,
                           input int exp_lat, input string nm, input bit hs);
        int edges;
        bit busy_ok;
        @(negedge clk);
        chk({nm, ":in_ready_idle"}, sel ? in_ready4 : in_ready, 1);
        if (sel) begin in_valid4 = 1'b1; in_y4 = y; end
        else     begin in_valid  = 1'b1; in_y  = y; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_valid4 = 1'b0;
        edges = 0;
        busy_ok = 1'b1;
        while (!(sel ? out_valid4 : out_valid) && edges < 40) begin
            if (sel ? in_ready4 : in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
        if (sel ? in_ready4 : in_ready) busy_ok = 1'b0;
        chk({nm, ":latency"}, edges, exp_lat);
        chk({nm, ":in_ready_busy"}, busy_ok, 1);
        chk({nm, ":out_x"}, sel ? out_x4 : out_x, exp_x);
`ifdef SIGMOID_INV_RESID_EN
        if (!sel) begin
            int r;
            r = f_ref($signed(exp_x)) - int'(y);
            if (r > 255) r = 255;
            if (r < 0) r = 0;
            chk({nm, ":resid"}, out_resid, r);
        end
`endif
        if (hs) begin
            @(negedge clk);
            out_ready = 1'b1; out_ready4 = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0; out_ready4 = 1'b0;
            chk({nm, ":valid_drop"}, sel ? out_valid4 : out_valid, 0);
            chk({nm, ":ready_back"}, sel ? in_ready4 : in_ready, 1);
        end
    endtask

    initial begin
        bit stale;
        vecs[0] = '{y: 8'd128, x: 8'h00, nm: "y128"};
        vecs[1] = '{y: 8'd0,   x: 8'h80, nm: "y0"};
        vecs[2] = '{y: 8'd255, x: 8'h4E, nm: "y255"};
        vecs[3] = '{y: 8'd192, x: 8'h10, nm: "y192"};
        vecs[4] = '{y: 8'd64,  x: 8'hF0, nm: "y64"};
        vecs[5] = '{y: 8'd236, x: 8'h28, nm: "y236"};
        vecs[6] = '{y: 8'd200, x: 8'h14, nm: "y200"};

        rst = 1'b1;
        in_valid = 1'b0; in_y = 8'd0; out_ready = 1'b0;
        in_valid4 = 1'b0; in_y4 = 8'd0; out_ready4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset:out_valid", out_valid, 0);
        chk("reset:out_x", out_x, 8'h00);
        chk("reset:in_ready", in_ready, 1);
        chk("reset4:in_ready", in_ready4, 1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            run_req(1'b0, vecs[i].y, vecs[i].x, 9, vecs[i].nm, 1'b1);

        // Four bisection steps leave lo at 128, 192 and 0 for these targets.
        run_req(1'b1, 8'd128, 8'h00, 5, "it4_y128", 1'b1);
        run_req(1'b1, 8'd255, 8'h40, 5, "it4_y255", 1'b1);
        run_req(1'b1, 8'd0,   8'h80, 5, "it4_y0",   1'b1);

        run_req(1'b0, 8'd128, 8'h00, 9, "bp", 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_y = 8'd5;
            @(posedge clk); #1;
            chk("bp:hold_valid", out_valid, 1);
            chk("bp:hold_x", out_x, 8'h00);
            chk("bp:hold_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp:release_valid", out_valid, 0);
        chk("bp:release_ready", in_ready, 1);
        run_req(1'b0, 8'd192, 8'h10, 9, "bp_next", 1'b1);

        @(negedge clk);
        in_valid = 1'b1; in_y = 8'd100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid:out_valid", out_valid, 0);
        chk("rst_mid:out_x", out_x, 8'h00);
        chk("rst_mid:in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        stale = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        chk("rst_mid:no_stale", stale, 0);
        run_req(1'b0, 8'd200, 8'h14, 9, "rst_next", 1'b1);

        for (int y = 0; y < 256; y++)
            run_req(1'b0, 8'(y), 8'(ref_x(y)), 9, $sformatf("sweep%0d", y), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
